// File: rtl/ring_counter_decoder.sv
// Receive-side checker for a one-hot ring counter: decodes the sampled position,
// tracks rotation lock, and reports violations, an error count and start-position wraps.
module ring_counter_decoder #(
   parameter int WIDTH    = 8,
   parameter int LOCK_CNT = 3,
   parameter int DIR_LEFT = 1,
   parameter int ERRW     = 8
) (
   input  logic                     clk,
   input  logic                     init,
   input  logic                     en,
   input  logic [WIDTH-1:0]         ring_in,
   output logic [$clog2(WIDTH)-1:0] index,
   output logic                     index_valid,
   output logic                     locked,
   output logic                     err,
   output logic [ERRW-1:0]          err_count,
   output logic                     wrap
);

   localparam int IW = $clog2(WIDTH);
   localparam int GW = $clog2(LOCK_CNT + 1);
   localparam logic [GW-1:0] LAST_GOOD = GW'(LOCK_CNT - 1);
   localparam logic [WIDTH-1:0] START_POS =
      (DIR_LEFT != 0) ? WIDTH'(1) : {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {HUNT, SYNC, LOCKED} state_t;

   state_t           state_q;
   logic [WIDTH-1:0] prev_q;
   logic [GW-1:0]    good_cnt_q;
   logic [IW-1:0]    index_q;
   logic             index_valid_q;
   logic             locked_q;
   logic             err_q;
   logic [ERRW-1:0]  err_count_q;
   logic             wrap_q;

   logic [WIDTH-1:0] rot_d;
   logic [IW-1:0]    pos_d;
   logic             onehot_d;
   logic             match_d;

   // Expected successor of the previous sample; wraps MSB<->bit0 for any WIDTH.
   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_rot
         if (DIR_LEFT != 0) begin : g_left
            assign rot_d[gi] = prev_q[(gi + WIDTH - 1) % WIDTH];
         end else begin : g_right
            assign rot_d[gi] = prev_q[(gi + 1) % WIDTH];
         end
      end
   endgenerate

   always_comb begin
      onehot_d = (ring_in != '0) && ((ring_in & (ring_in - WIDTH'(1))) == '0);
      match_d  = (ring_in == rot_d);
      pos_d    = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (ring_in[i]) begin
            pos_d = pos_d | IW'(i);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (init) begin
         state_q       <= HUNT;
         prev_q        <= '0;
         good_cnt_q    <= '0;
         index_q       <= '0;
         index_valid_q <= 1'b0;
         locked_q      <= 1'b0;
         err_q         <= 1'b0;
         err_count_q   <= '0;
         wrap_q        <= 1'b0;
      end else if (!en) begin
         err_q  <= 1'b0;
         wrap_q <= 1'b0;
      end else begin
         err_q         <= 1'b0;
         wrap_q        <= 1'b0;
         index_valid_q <= onehot_d;
         if (onehot_d) begin
            index_q <= pos_d;
         end
         case (state_q)
            HUNT: begin
               if (onehot_d) begin
                  prev_q     <= ring_in;
                  good_cnt_q <= '0;
                  state_q    <= SYNC;
               end
            end
            SYNC: begin
               if (match_d) begin
                  prev_q     <= ring_in;
                  good_cnt_q <= good_cnt_q + GW'(1);
                  if (good_cnt_q == LAST_GOOD) begin
                     state_q  <= LOCKED;
                     locked_q <= 1'b1;
                  end
               end else if (onehot_d) begin
                  prev_q     <= ring_in;
                  good_cnt_q <= '0;
               end else begin
                  state_q <= HUNT;
               end
            end
            LOCKED: begin
               if (match_d) begin
                  prev_q <= ring_in;
                  wrap_q <= (ring_in == START_POS);
               end else begin
                  err_q    <= 1'b1;
                  locked_q <= 1'b0;
                  if (err_count_q != '1) begin
                     err_count_q <= err_count_q + ERRW'(1);
                  end
                  if (onehot_d) begin
                     prev_q     <= ring_in;
                     good_cnt_q <= '0;
                     state_q    <= SYNC;
                  end else begin
                     state_q <= HUNT;
                  end
               end
            end
            default: begin
               state_q  <= HUNT;
               locked_q <= 1'b0;
            end
         endcase
      end
   end

   assign index       = index_q;
   assign index_valid = index_valid_q;
   assign locked      = locked_q;
   assign err         = err_q;
   assign err_count   = err_count_q;
   assign wrap        = wrap_q;

endmodule

// File: tb/tb_ring_counter_decoder.sv
// Directed vector bench: a default left-rotating 8-bit instance and a small
// right-rotating 4-bit instance with a 2-bit error counter for saturation.
module tb_ring_counter_decoder;

   typedef struct {
      logic       init;
      logic       en;
      logic [7:0] ring;
      logic [2:0] idx;
      logic       v;
      logic       lk;
      logic       er;
      logic       wr;
      logic [7:0] cnt;
   } vec_t;

   logic       clk;
   logic       init_a, en_a;
   logic [7:0] ring_a;
   logic [2:0] index_a;
   logic       index_valid_a, locked_a, err_a, wrap_a;
   logic [7:0] err_count_a;

   logic       init_b, en_b;
   logic [3:0] ring_b;
   logic [1:0] index_b;
   logic       index_valid_b, locked_b, err_b, wrap_b;
   logic [1:0] err_count_b;

   int n_vec  = 0;
   int n_fail = 0;

   vec_t va[$];
   vec_t vb[$];

   ring_counter_decoder #(.WIDTH(8), .LOCK_CNT(3), .DIR_LEFT(1), .ERRW(8)) dut_a (
      .clk(clk), .init(init_a), .en(en_a), .ring_in(ring_a),
      .index(index_a), .index_valid(index_valid_a), .locked(locked_a),
      .err(err_a), .err_count(err_count_a), .wrap(wrap_a)
   );

   ring_counter_decoder #(.WIDTH(4), .LOCK_CNT(1), .DIR_LEFT(0), .ERRW(2)) dut_b (
      .clk(clk), .init(init_b), .en(en_b), .ring_in(ring_b),
      .index(index_b), .index_valid(index_valid_b), .locked(locked_b),
      .err(err_b), .err_count(err_count_b), .wrap(wrap_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t mk(logic i, logic e, logic [7:0] r, logic [2:0] x,
                               logic v, logic l, logic er, logic w, logic [7:0] c);
      vec_t t;
      t.init = i; t.en = e; t.ring = r; t.idx = x;
      t.v = v; t.lk = l; t.er = er; t.wr = w; t.cnt = c;
      return t;
   endfunction

   task automatic chk(input int vn, input string name, input logic [7:0] act, input logic [7:0] exp);
      if (act !== exp) begin
         n_fail++;
         $display("FAIL vec %0d %s: got %h expected %h", vn, name, act, exp);
      end
   endtask

   task automatic apply(input int which, input vec_t t);
      logic [7:0] a_idx, a_cnt;
      logic       a_v, a_lk, a_er, a_wr;
      if (which == 0) begin
         init_a = t.init; en_a = t.en; ring_a = t.ring;
      end else begin
         init_b = t.init; en_b = t.en; ring_b = t.ring[3:0];
      end
      @(posedge clk);
      #1;
      if (which == 0) begin
         a_idx = {5'd0, index_a}; a_v = index_valid_a; a_lk = locked_a;
         a_er = err_a; a_wr = wrap_a; a_cnt = err_count_a;
      end else begin
         a_idx = {6'd0, index_b}; a_v = index_valid_b; a_lk = locked_b;
         a_er = err_b; a_wr = wrap_b; a_cnt = {6'd0, err_count_b};
      end
      n_vec++;
      $display("vec %0d dut%0d init=%b en=%b ring=%h -> idx=%0d v=%b lk=%b err=%b wrap=%b cnt=%0d",
               n_vec, which, t.init, t.en, t.ring, a_idx, a_v, a_lk, a_er, a_wr, a_cnt);
      chk(n_vec, "index", a_idx, {5'd0, t.idx});
      chk(n_vec, "index_valid", {7'd0, a_v}, {7'd0, t.v});
      chk(n_vec, "locked", {7'd0, a_lk}, {7'd0, t.lk});
      chk(n_vec, "err", {7'd0, a_er}, {7'd0, t.er});
      chk(n_vec, "wrap", {7'd0, a_wr}, {7'd0, t.wr});
      chk(n_vec, "err_count", a_cnt, t.cnt);
   endtask

   initial begin
      vec_t hold;
      init_a = 1'b1; en_a = 1'b0; ring_a = 8'h00;
      init_b = 1'b1; en_b = 1'b0; ring_b = 4'h0;

      //               init en  ring   idx v lk er wr cnt
      va.push_back(mk(1, 1, 8'h00, 0, 0, 0, 0, 0, 0));
      // lock-up
      va.push_back(mk(0, 1, 8'h01, 0, 1, 0, 0, 0, 0));
      va.push_back(mk(0, 1, 8'h02, 1, 1, 0, 0, 0, 0));
      va.push_back(mk(0, 1, 8'h04, 2, 1, 0, 0, 0, 0));
      va.push_back(mk(0, 1, 8'h08, 3, 1, 1, 0, 0, 0));
      // wrap through MSB back to bit0
      va.push_back(mk(0, 1, 8'h10, 4, 1, 1, 0, 0, 0));
      va.push_back(mk(0, 1, 8'h20, 5, 1, 1, 0, 0, 0));
      va.push_back(mk(0, 1, 8'h40, 6, 1, 1, 0, 0, 0));
      va.push_back(mk(0, 1, 8'h80, 7, 1, 1, 0, 0, 0));
      va.push_back(mk(0, 1, 8'h01, 0, 1, 1, 0, 1, 0));
      va.push_back(mk(0, 0, 8'h02, 0, 1, 1, 0, 0, 0));
      va.push_back(mk(0, 1, 8'h02, 1, 1, 1, 0, 0, 0));
      va.push_back(mk(0, 1, 8'h04, 2, 1, 1, 0, 0, 0));
      // rotation violation with a legal code -> SYNC, relock
      va.push_back(mk(0, 1, 8'h20, 5, 1, 0, 1, 0, 1));
      va.push_back(mk(0, 1, 8'h40, 6, 1, 0, 0, 0, 1));
      va.push_back(mk(0, 1, 8'h80, 7, 1, 0, 0, 0, 1));
      va.push_back(mk(0, 1, 8'h01, 0, 1, 1, 0, 0, 1));
      va.push_back(mk(0, 1, 8'h02, 1, 1, 1, 0, 0, 1));
      // illegal codes -> HUNT, index held
      va.push_back(mk(0, 1, 8'h00, 1, 0, 0, 1, 0, 2));
      va.push_back(mk(0, 1, 8'h03, 1, 0, 0, 0, 0, 2));
      va.push_back(mk(0, 1, 8'h10, 4, 1, 0, 0, 0, 2));
      // stall in SYNC with garbage on the ring
      va.push_back(mk(0, 0, 8'h20, 4, 1, 0, 0, 0, 2));
      va.push_back(mk(0, 0, 8'hFF, 4, 1, 0, 0, 0, 2));
      va.push_back(mk(0, 0, 8'h00, 4, 1, 0, 0, 0, 2));
      va.push_back(mk(0, 1, 8'h20, 5, 1, 0, 0, 0, 2));
      va.push_back(mk(0, 1, 8'h40, 6, 1, 0, 0, 0, 2));
      va.push_back(mk(0, 1, 8'h80, 7, 1, 1, 0, 0, 2));
      // stalled frozen value is fine; enabled frozen value is a violation
      va.push_back(mk(0, 0, 8'h80, 7, 1, 1, 0, 0, 2));
      va.push_back(mk(0, 1, 8'h80, 7, 1, 0, 1, 0, 3));
      va.push_back(mk(0, 1, 8'h01, 0, 1, 0, 0, 0, 3));
      va.push_back(mk(0, 1, 8'h02, 1, 1, 0, 0, 0, 3));
      va.push_back(mk(0, 1, 8'h04, 2, 1, 1, 0, 0, 3));
      // init mid-lock wins over en=0
      va.push_back(mk(1, 0, 8'h08, 0, 0, 0, 0, 0, 0));
      va.push_back(mk(0, 1, 8'h01, 0, 1, 0, 0, 0, 0));
      va.push_back(mk(0, 1, 8'h02, 1, 1, 0, 0, 0, 0));
      va.push_back(mk(0, 1, 8'h04, 2, 1, 0, 0, 0, 0));
      va.push_back(mk(0, 1, 8'h08, 3, 1, 1, 0, 0, 0));

      // 4-bit right rotation, lock after a single step, 2-bit saturating count
      vb.push_back(mk(1, 1, 8'h0, 0, 0, 0, 0, 0, 0));
      vb.push_back(mk(0, 1, 8'h4, 2, 1, 0, 0, 0, 0));
      vb.push_back(mk(0, 1, 8'h2, 1, 1, 1, 0, 0, 0));
      vb.push_back(mk(0, 1, 8'h1, 0, 1, 1, 0, 0, 0));
      vb.push_back(mk(0, 1, 8'h8, 3, 1, 1, 0, 1, 0));
      vb.push_back(mk(0, 1, 8'h8, 3, 1, 0, 1, 0, 1));
      vb.push_back(mk(0, 1, 8'h4, 2, 1, 1, 0, 0, 1));
      vb.push_back(mk(0, 1, 8'h4, 2, 1, 0, 1, 0, 2));
      vb.push_back(mk(0, 1, 8'h2, 1, 1, 1, 0, 0, 2));
      vb.push_back(mk(0, 1, 8'h2, 1, 1, 0, 1, 0, 3));
      vb.push_back(mk(0, 1, 8'h1, 0, 1, 1, 0, 0, 3));
      vb.push_back(mk(0, 1, 8'h1, 0, 1, 0, 1, 0, 3));
      vb.push_back(mk(0, 1, 8'h8, 3, 1, 1, 0, 0, 3));
      vb.push_back(mk(0, 1, 8'h8, 3, 1, 0, 1, 0, 3));

      foreach (va[i]) apply(0, va[i]);
      en_a = 1'b0; init_a = 1'b0;
      foreach (vb[i]) apply(1, vb[i]);

      // Long stall with random ring values right after an err pulse.
      hold = mk(0, 0, 8'h0, 3, 1, 0, 0, 0, 3);
      for (int k = 0; k < 10; k++) begin
         hold.ring = 8'($urandom_range(0, 15));
         apply(1, hold);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
